// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit and the ALU control.
// Holds the FSM state type, the opcode constants and the ALU operand/op select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH,
        ILLEGAL
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Loads and stores share MEM_ADDR; opcode bit 5 is the only difference.
    function automatic logic is_store(input logic [6:0] opc);
        return opc[5];
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit and the datapath: decoder/memory status in,
// datapath enables, mux selects and performance counters out.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             mem_to_reg;
    logic             pc_source;
    logic             illegal;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_source, illegal,
               cycle_count, instr_count
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_source, illegal,
               cycle_count, instr_count
    );

endinterface

// File: rtl/multicycle_control_perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RISC-V datapath: fetch, decode, execute,
// memory and write-back, plus cycle and retired-instruction counters.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                clk,
    input logic                rst,
    multicycle_control_if.master bus
);

    state_t state;
    logic   retire;
    logic   unused_funct;

    // funct7[5] and funct3[2:1] only matter to the ALU control, not to sequencing.
    assign unused_funct = &{1'b0, bus.funct7_5, bus.funct3[2:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:     if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OPC_LOAD, OPC_STORE: state <= MEM_ADDR;
                        OPC_OP:              state <= EXEC_R;
                        OPC_OP_IMM:          state <= EXEC_I;
                        OPC_BRANCH:          state <= BRANCH;
                        default:             state <= ILLEGAL;
                    endcase
                end
                MEM_ADDR:  state <= is_store(bus.opcode) ? MEM_WRITE : MEM_READ;
                MEM_READ:  if (bus.mem_ready) state <= MEM_WB;
                MEM_WRITE: if (bus.mem_ready) state <= FETCH;
                EXEC_R:    state <= ALU_WB;
                EXEC_I:    state <= ALU_WB;
                MEM_WB:    state <= FETCH;
                ALU_WB:    state <= FETCH;
                BRANCH:    state <= FETCH;
                ILLEGAL:   state <= FETCH;
                default:   state <= FETCH;
            endcase
        end
    end

    // Outputs decode the state register; only FETCH and BRANCH look at live inputs.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRC_B_RS2;
        bus.alu_op     = ALU_OP_ADD;
        bus.mem_to_reg = 1'b0;
        bus.pc_source  = 1'b0;
        bus.illegal    = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRC_B_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_b = SRC_B_IMM;
                end
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRC_B_IMM;
                end
                MEM_READ: begin
                    bus.mem_read = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    bus.mem_write = 1'b1;
                end
                EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRC_B_RS2;
                    bus.alu_op    = ALU_OP_FUNCT;
                end
                EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRC_B_IMM;
                    bus.alu_op    = ALU_OP_FUNCT;
                end
                ALU_WB: begin
                    bus.reg_write = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRC_B_RS2;
                    bus.alu_op    = ALU_OP_SUB;
                    bus.pc_source = 1'b1;
                    bus.pc_write  = bus.zero ^ bus.funct3[0];
                end
                ILLEGAL: begin
                    bus.illegal = 1'b1;
                end
                default: begin
                    bus.illegal = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            MEM_WB, ALU_WB, BRANCH: retire = 1'b1;
            MEM_WRITE:              retire = bus.mem_ready;
            default:                retire = 1'b0;
        endcase
    end

    perf_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .count (bus.cycle_count)
    );

    perf_counter #(.CNT_W(CNT_W)) u_instr_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (bus.instr_count)
    );

endmodule
